reorder_buffer: RTL
===================

# reorder_buffer

Parametrised circular reorder buffer for the out-of-order core. It allocates entries for up to DISP_WIDTH instructions per cycle at dispatch, and accepts out-of-order completion from WB_PORTS writeback ports. It retires up to RETIRE_WIDTH ready instructions per cycle in program order. A retiring entry marked mispredicted or excepting retires as the last instruction of its group and flushes the whole buffer.

## Interface
Parameters:
- ENTRIES, 16, buffer depth; power of two, ≥ max(DISP_WIDTH, RETIRE_WIDTH); IW = $clog2(ENTRIES)
- DISP_WIDTH, 2, dispatch lanes
- WB_PORTS, 2, writeback ports
- RETIRE_WIDTH, 2, retire lanes
- AREG_W, 5, architectural register index width
- PREG_W, 6, physical register index width

Ports (lane arrays are [N-1:0] of the stated width):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- disp_valid  in  DISP_WIDTH  per-lane dispatch request; may be non-contiguous
- disp_areg / disp_preg  in  DISP_WIDTH×AREG_W / ×PREG_W  destination registers
- disp_wb_en  in  DISP_WIDTH  instruction writes a register
- disp_pc  in  DISP_WIDTH×32  instruction PC
- disp_ready  out  1  dispatch accepted this cycle when high
- disp_idx  out  DISP_WIDTH×IW  allocated entry index per lane (combinational)
- wb_valid  in  WB_PORTS  completion strobe
- wb_idx  in  WB_PORTS×IW  completing entry
- wb_result  in  WB_PORTS×32  result value
- wb_mispred / wb_exception  in  WB_PORTS  completion flags
- ret_valid  out  RETIRE_WIDTH  lane k retires this cycle
- ret_areg / ret_preg / ret_wb_en / ret_result / ret_pc  out  per lane  retiring entry fields
- flush  out  1  a mispred/exception entry retires this cycle
- flush_pc  out  32  PC of that entry; 0 when flush low
- count  out  $clog2(ENTRIES+1)  occupied entries
- empty / full  out  1  count==0 / count==ENTRIES

## Operation
- State: per-entry valid, ready, mispred, exception, areg, preg, wb_en, pc, result; head, tail (IW bits, wrap mod ENTRIES); count.
- Dispatch: disp_ready = (ENTRIES − count ≥ DISP_WIDTH) && !flush. Free space is measured at the start of the cycle; slots freed by a same-cycle retire are not reusable until the next cycle.
- Lane compaction: disp_idx[k] = tail + popcount(disp_valid[k-1:0]). Lanes with disp_valid low are given an index but do not allocate.
- Accepted entries are written with valid=1 and ready/mispred/exception=0. tail advances by popcount(disp_valid).
- Writeback: if wb_valid[p] and entry wb_idx[p] is valid, set ready=1 and write result, mispred and exception. Writeback to an invalid entry is ignored. If two ports target the same index, the lowest-numbered port wins.
- Retire (combinational from registered state): ret_valid[k] = entry (head+k) is valid && ready, AND all lanes <k retire, AND no lane <k has mispred|exception. Commit cannot stall a retire.
- Retired entries are invalidated. head advances by the number retired.
- Flush: asserted when the highest retiring lane has mispred|exception. At that edge, all entries are invalidated and head=tail=count=0. Dispatch and writeback in the flush cycle are discarded.
- count_next = count + accepted − retired (0 on flush).

## Timing
- Reset: all entries invalid; head=tail=count=0. Outputs: ret_valid=0, flush=0, flush_pc=0, empty=1, full=0, count=0, disp_ready=1.
- Reset takes priority over dispatch, writeback and retire in the same cycle.
- Dispatch → earliest writeback: next cycle.
- Writeback → earliest retire: next cycle (no same-cycle bypass into retire).
- Retire and flush are decided in the same cycle from current state. Post-flush state is visible in the next cycle.
- Wrap: head/tail roll from ENTRIES−1 to 0. Full vs empty is disambiguated by count only.
- Simultaneous dispatch, writeback and retire to distinct entries in one cycle: all take effect.

## Test plan
- Reset, then dispatch 2 (pc 0x100, 0x104) → disp_idx {0,1}, count 2. Writeback idx1 then idx0 on later cycles → both retire in the same cycle, ret_pc {0x100, 0x104}, count 0.
- Fill 16 entries (8 cycles of 2) → full=1, disp_ready=0. Retire 1 → disp_ready stays 0 (15 used, only 1 free). Retire 1 more → disp_ready=1.
- disp_valid=2'b10 → lane 1 gets disp_idx = tail, count+1. Lane 0 does not allocate.
- Entries 0..3 ready, entry 1 wb_mispred, pc 0x200 → cycle 1: ret_valid=2'b11, flush=1, flush_pc=0x200. Next cycle: count 0, empty=1, head=tail=0. Entries 2–3 are never retired.
- Wrap: run 40 dispatch/retire pairs with head near 15 → indices wrap to 0 and retire order is preserved.
- Writeback to idx 5 while it is invalid → no effect. Ports 0 and 1 both write idx 3 (results 0xA, 0xB) → retire shows 0xA.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane dispatch, out-of-order writeback,
// in-order multi-lane retire with flush on a mispredicted/excepting entry.
module reorder_buffer #(
    parameter int ENTRIES      = 16,
    parameter int DISP_WIDTH   = 2,
    parameter int WB_PORTS     = 2,
    parameter int RETIRE_WIDTH = 2,
    parameter int AREG_W       = 5,
    parameter int PREG_W       = 6,
    localparam int IW          = $clog2(ENTRIES),
    localparam int CW          = $clog2(ENTRIES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DISP_WIDTH-1:0]          disp_valid,
    input  logic [DISP_WIDTH*AREG_W-1:0]   disp_areg,
    input  logic [DISP_WIDTH*PREG_W-1:0]   disp_preg,
    input  logic [DISP_WIDTH-1:0]          disp_wb_en,
    input  logic [DISP_WIDTH*32-1:0]       disp_pc,
    output logic                           disp_ready,
    output logic [DISP_WIDTH*IW-1:0]       disp_idx,
    input  logic [WB_PORTS-1:0]            wb_valid,
    input  logic [WB_PORTS*IW-1:0]         wb_idx,
    input  logic [WB_PORTS*32-1:0]         wb_result,
    input  logic [WB_PORTS-1:0]            wb_mispred,
    input  logic [WB_PORTS-1:0]            wb_exception,
    output logic [RETIRE_WIDTH-1:0]        ret_valid,
    output logic [RETIRE_WIDTH*AREG_W-1:0] ret_areg,
    output logic [RETIRE_WIDTH*PREG_W-1:0] ret_preg,
    output logic [RETIRE_WIDTH-1:0]        ret_wb_en,
    output logic [RETIRE_WIDTH*32-1:0]     ret_result,
    output logic [RETIRE_WIDTH*32-1:0]     ret_pc,
    output logic                           flush,
    output logic [31:0]                    flush_pc,
    output logic [CW-1:0]                  count,
    output logic                           empty,
    output logic                           full
);

    logic [ENTRIES-1:0] e_valid, e_ready, e_mp, e_ex, e_wb_en;
    logic [AREG_W-1:0]  e_areg   [ENTRIES];
    logic [PREG_W-1:0]  e_preg   [ENTRIES];
    logic [31:0]        e_pc     [ENTRIES];
    logic [31:0]        e_result [ENTRIES];

    logic [IW-1:0] head, tail;
    logic [CW-1:0] count_q;

    logic [IW-1:0] disp_slot [DISP_WIDTH];
    logic [CW-1:0] disp_n;
    logic [IW-1:0] ret_slot  [RETIRE_WIDTH];
    logic [CW-1:0] ret_n;
    logic          ret_go;
    logic [WB_PORTS-1:0] wb_take;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(ENTRIES));

    // Free space is judged on start-of-cycle occupancy only.
    assign disp_ready = (({1'b0, count_q} + (CW+1)'(DISP_WIDTH)) <= (CW+1)'(ENTRIES)) && !flush;

    always_comb begin
        disp_n   = '0;
        disp_idx = '0;
        for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
            disp_slot[k] = tail + IW'(disp_n);
            disp_idx[k*IW +: IW] = disp_slot[k];
            disp_n = disp_n + CW'(disp_valid[k]);
        end
    end

    always_comb begin
        ret_valid  = '0;
        ret_areg   = '0;
        ret_preg   = '0;
        ret_wb_en  = '0;
        ret_result = '0;
        ret_pc     = '0;
        ret_n      = '0;
        ret_go     = 1'b1;
        flush      = 1'b0;
        flush_pc   = '0;
        for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
            ret_slot[k] = head + IW'(k);
            ret_areg[k*AREG_W +: AREG_W] = e_areg[ret_slot[k]];
            ret_preg[k*PREG_W +: PREG_W] = e_preg[ret_slot[k]];
            ret_wb_en[k]                 = e_wb_en[ret_slot[k]];
            ret_result[k*32 +: 32]       = e_result[ret_slot[k]];
            ret_pc[k*32 +: 32]           = e_pc[ret_slot[k]];
            if (ret_go && e_valid[ret_slot[k]] && e_ready[ret_slot[k]]) begin
                ret_valid[k] = 1'b1;
                ret_n        = ret_n + CW'(1);
                // A mispredicted/excepting entry ends the group and flushes.
                if (e_mp[ret_slot[k]] || e_ex[ret_slot[k]]) begin
                    flush    = 1'b1;
                    flush_pc = e_pc[ret_slot[k]];
                    ret_go   = 1'b0;
                end
            end else begin
                ret_go = 1'b0;
            end
        end
    end

    // Lowest-numbered port wins when several target the same entry.
    always_comb begin
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            wb_take[p] = wb_valid[p] && e_valid[wb_idx[p*IW +: IW]];
            for (int unsigned q = 0; q < p; q++) begin
                if (wb_valid[q] && (wb_idx[q*IW +: IW] == wb_idx[p*IW +: IW]))
                    wb_take[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            e_valid <= '0;
            e_ready <= '0;
            e_mp    <= '0;
            e_ex    <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned p = 0; p < WB_PORTS; p++) begin
                if (wb_take[p]) begin
                    e_ready[wb_idx[p*IW +: IW]]  <= 1'b1;
                    e_result[wb_idx[p*IW +: IW]] <= wb_result[p*32 +: 32];
                    e_mp[wb_idx[p*IW +: IW]]     <= wb_mispred[p];
                    e_ex[wb_idx[p*IW +: IW]]     <= wb_exception[p];
                end
            end
            for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
                if (ret_valid[k])
                    e_valid[ret_slot[k]] <= 1'b0;
            end
            if (disp_ready) begin
                for (int unsigned k = 0; k < DISP_WIDTH; k++) begin
                    if (disp_valid[k]) begin
                        e_valid[disp_slot[k]] <= 1'b1;
                        e_ready[disp_slot[k]] <= 1'b0;
                        e_mp[disp_slot[k]]    <= 1'b0;
                        e_ex[disp_slot[k]]    <= 1'b0;
                        e_wb_en[disp_slot[k]] <= disp_wb_en[k];
                        e_areg[disp_slot[k]]  <= disp_areg[k*AREG_W +: AREG_W];
                        e_preg[disp_slot[k]]  <= disp_preg[k*PREG_W +: PREG_W];
                        e_pc[disp_slot[k]]    <= disp_pc[k*32 +: 32];
                    end
                end
            end
            head    <= head + IW'(ret_n);
            tail    <= tail + (disp_ready ? IW'(disp_n) : '0);
            count_q <= count_q + (disp_ready ? disp_n : '0) - ret_n;
        end
    end

endmodule
